// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared constants and compare helpers for pattern_seq_detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Helper functions operate on a fixed wide vector; callers zero-extend.
    localparam int unsigned      C_FN_W    = 32;
    localparam logic [C_FN_W-1:0] C_ONE    = 32'd1;
    localparam logic [7:0]       C_DEF_PAT = 8'b0000_1011;
    localparam int unsigned      C_DEF_LEN = 4;

    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

    // True when the low len bits of hist equal the low len bits of pat.
    function automatic logic masked_match(input logic [C_FN_W-1:0] pat,
                                          input logic [C_FN_W-1:0] hist,
                                          input int unsigned       len);
        logic [C_FN_W-1:0] mask;
        if (len >= C_FN_W) begin
            mask = '1;
        end else begin
            mask = (C_ONE << len) - C_ONE;
        end
        return ((pat ^ hist) & mask) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_seq_detector_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear (clear wins).
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pattern_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : pattern_seq_detector
// Description : Runtime-programmable serial pattern detector, registered match.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN = 8,
    parameter int unsigned          LEN_W   = 4,
    parameter int unsigned          CNT_W   = 8,
    parameter logic [MAX_LEN-1:0]   DEF_PAT = MAX_LEN'(C_DEF_PAT),
    parameter int unsigned          DEF_LEN = C_DEF_LEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               clr_count,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill
);

    localparam logic [LEN_W-1:0] C_MAX_FILL = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d, w_hist_n;
    logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d, w_fill_n;
    logic               z_q, z_d;
    logic               w_hit, w_inc;
    logic [C_FN_W-1:0]  w_pat_ext, w_hist_ext;
    // The oldest history bit shifts out without ever being compared.
    logic               w_unused_oldest;

    assign w_unused_oldest = hist_q[MAX_LEN-1];
    assign w_hist_n = {hist_q[MAX_LEN-2:0], x};
    assign w_fill_n = (fill_q >= C_MAX_FILL) ? C_MAX_FILL : fill_q + LEN_W'(1);

    always_comb begin
        w_pat_ext                = '0;
        w_hist_ext               = '0;
        w_pat_ext[MAX_LEN-1:0]   = pat_q;
        w_hist_ext[MAX_LEN-1:0]  = w_hist_n;
    end

    assign w_hit = (len_q != '0) && (w_fill_n >= len_q)
                   && masked_match(w_pat_ext, w_hist_ext, 32'(len_q));
    assign w_inc = w_hit && x_valid && !pat_load;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PAT;
            len_q  <= LEN_W'(DEF_LEN);
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            z_q    <= z_d;
        end
    end

    // Next-state logic: a load flushes history and drops the bit on x.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        z_d    = 1'b0;
        if (pat_load) begin
            pat_d  = pat_in;
            len_d  = LEN_W'(clamp_len(32'(len_in), MAX_LEN));
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = w_hist_n;
            z_d    = w_hit;
            fill_d = (w_hit && !overlap) ? '0 : w_fill_n;
        end
    end

    // Outputs
    assign z    = z_q;
    assign fill = fill_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (w_inc),
        .clr_i   (clr_count),
        .count_o (match_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pattern_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_seq_detector
// Description : Self-checking bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_seq_detector;

    logic       clk = 1'b0;
    logic       reset, x, x_valid, overlap, pat_load, clr_count;
    logic [7:0] pat_in;
    logic [3:0] len_in;
    logic       z;
    logic [7:0] match_count;
    logic [3:0] fill;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model: the accepted bits since the last flush, oldest first.
    bit         mq[$];
    logic [7:0] mpat;
    int         mlen;
    int         mcnt;
    int         exp_z;
    int         exp_fill;

    always #5 clk = ~clk;

    pattern_seq_detector dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .x_valid     (x_valid),
        .overlap     (overlap),
        .pat_load    (pat_load),
        .pat_in      (pat_in),
        .len_in      (len_in),
        .clr_count   (clr_count),
        .z           (z),
        .match_count (match_count),
        .fill        (fill)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("z", int'(z), exp_z);
            chk("match_count", int'(match_count), mcnt);
            chk("fill", int'(fill), exp_fill);
        end
    end

    task automatic model_update(input bit b, input bit vld, input bit ov, input bit ld,
                                input logic [7:0] p, input logic [3:0] l,
                                input bit clr, input bit rst);
        bit hit;
        hit = 1'b0;
        if (rst) begin
            mpat = 8'h0B;
            mlen = 4;
            mq.delete();
            mcnt = 0;
        end else begin
            if (ld) begin
                mpat = p;
                mlen = (l > 4'd8) ? 8 : int'(l);
                mq.delete();
            end else if (vld) begin
                mq.push_back(b);
                if (mq.size() > 8) void'(mq.pop_front());
                if (mlen != 0 && mq.size() >= mlen) begin
                    hit = 1'b1;
                    for (int i = 0; i < mlen; i++)
                        if (mq[mq.size() - 1 - i] != mpat[i]) hit = 1'b0;
                end
                if (hit && !ov) mq.delete();
            end
            if (clr) mcnt = 0;
            else if (hit && mcnt < 255) mcnt++;
        end
        exp_z    = int'(hit);
        exp_fill = mq.size();
    endtask

    task automatic step(input bit b, input bit vld, input bit ov, input bit ld,
                        input logic [7:0] p, input logic [3:0] l,
                        input bit clr, input bit rst);
        reset = rst; x = b; x_valid = vld; overlap = ov;
        pat_load = ld; pat_in = p; len_in = l; clr_count = clr;
        @(posedge clk);
        model_update(b, vld, ov, ld, p, l, clr, rst);
        #1;
    endtask

    task automatic send(input bit b, input bit ov);
        step(b, 1'b1, ov, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit clr);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, clr, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l);
        step(1'b0, 1'b0, 1'b1, 1'b1, p, l, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    endtask

    bit s[16] = '{0,0,1,0,1,1,0,1,1,0,0,1,0,1,1,0};

    initial begin
        logic [7:0] pv;
        int         base;
        bit         d4[4] = '{1,1,0,1};

        do_reset();
        do_reset();
        chk_en = 1'b1;
        chk("reset_z", int'(z), 0);
        chk("reset_count", int'(match_count), 0);
        chk("reset_fill", int'(fill), 0);

        // Default 1011, overlapping
        for (int i = 0; i < 16; i++) begin
            send(s[i], 1'b1);
            chk("ov_pulse", int'(z), int'(i == 5 || i == 8 || i == 14));
        end
        chk("ov_count", int'(match_count), 3);

        // Default 1011, non-overlapping
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(s[i], 1'b0);
            chk("nov_pulse", int'(z), int'(i == 5 || i == 14));
            if (i == 5 || i == 14) chk("nov_fill", int'(fill), 0);
        end
        chk("nov_count", int'(match_count), 2);

        // 8-bit loaded pattern, twice back to back, then with a valid gap
        pv = 8'hE5;
        load(pv, 4'd8);
        base = int'(match_count);
        for (int i = 0; i < 16; i++) begin
            send(pv[7 - (i % 8)], 1'b1);
            chk("len8_pulse", int'(z), int'(i == 7 || i == 15));
        end
        chk("len8_count", int'(match_count) - base, 2);
        load(pv, 4'd8);
        base = int'(match_count);
        for (int i = 0; i < 16; i++) begin
            send(pv[7 - (i % 8)], 1'b1);
            chk("gap_pulse", int'(z), int'(i == 7 || i == 15));
            if (i == 3) begin
                for (int k = 0; k < 3; k++) begin
                    idle(1'b0);
                    chk("gap_z_low", int'(z), 0);
                end
            end
        end
        chk("gap_count", int'(match_count) - base, 2);

        // len 0 disables, len 12 clamps to 8, len 1 single-bit compare
        load(8'hFF, 4'd0);
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 1'b1);
            chk("len0_z", int'(z), 0);
        end
        load(8'hFF, 4'd12);
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b0);
            chk("len12_pulse", int'(z), int'(i == 7));
        end
        load(8'h01, 4'd1);
        base = int'(match_count);
        for (int i = 0; i < 4; i++) begin
            send(d4[i], 1'b0);
            chk("len1_pulse", int'(z), int'(i != 2));
        end
        chk("len1_count", int'(match_count) - base, 3);

        // Counter saturation and clear-beats-hit
        idle(1'b1);
        for (int i = 0; i < 256; i++) send(1'b1, 1'b1);
        chk("sat_255", int'(match_count), 255);
        send(1'b1, 1'b1);
        chk("sat_hold", int'(match_count), 255);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
        chk("clr_hit_z", int'(z), 1);
        chk("clr_hit_count", int'(match_count), 0);

        // Reset mid-match, then load on the completing bit
        do_reset();
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
        do_reset();
        send(1'b1, 1'b1);
        chk("rst_mid_z", int'(z), 0);
        send(1'b0, 1'b1); send(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h0B, 4'd4, 1'b0, 1'b0);
        chk("load_drop_z", int'(z), 0);
        chk("load_drop_fill", int'(fill), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] rl;
            rl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 4));
            step(1'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom),
                 ($urandom_range(0, 63) == 0), 8'($urandom), rl,
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 511) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
